bram_queue_reader: RTL and testbench

- Read-side controller for a simple dual-port single-clock BRAM whose write port is driven by a producer.
- Tracks committed entries.
- Drives the BRAM read port (addrb/enb/regceb/rstb) and absorbs its 1- or 2-cycle read latency.
- Presents entries in order on a valid/ready stream with full throughput.
- Reports write address and full status back to the producer.

---
 rtl/bram_queue_reader.sv | 124 ++++++++++++
 tb/tb_bram_queue_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_queue_reader.sv
// rtl/bram_queue_reader.sv - read-side controller for a producer-filled dual-port BRAM queue
module bram_queue_reader #(
    parameter int RAM_WIDTH    = 678,
    parameter int RAM_DEPTH    = 16,
    parameter int READ_LATENCY = 1,
    localparam int AW          = $clog2(RAM_DEPTH - 1),
    localparam int BUF_DEPTH   = READ_LATENCY + 1
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 wr_push,
    output logic [AW-1:0]        wr_addr,
    output logic                 full,
    output logic [AW:0]          count,
    output logic                 overflow,
    output logic [AW-1:0]        addrb,
    output logic                 enb,
    output logic                 regceb,
    output logic                 rstb,
    input  logic [RAM_WIDTH-1:0] doutb,
    output logic                 m_valid,
    output logic [RAM_WIDTH-1:0] m_data,
    input  logic                 m_ready
);

    localparam int CW = $clog2(2 * BUF_DEPTH + 1);
    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            cnt;
    logic                   ovf;
    logic [READ_LATENCY-1:0] vld;
    logic [OW-1:0]          occ;
    logic [RAM_WIDTH-1:0]   buf_mem [BUF_DEPTH];

    logic          push_ok;
    logic          pop;
    logic          issue;
    logic          cap;
    logic [CW-1:0] inflight;
    logic [CW-1:0] level;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(vld[i]);
        end
    end

    assign full    = (cnt == (AW + 1)'(RAM_DEPTH));
    assign push_ok = wr_push && !full;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign cap     = vld[READ_LATENCY-1];

    // Reserve a buffer slot for every read already in flight so capture can never overflow.
    assign level = inflight + CW'(occ) - CW'(pop);
    assign issue = (cnt != '0) && (level < CW'(BUF_DEPTH));

    assign enb      = issue;
    assign addrb    = rd_ptr;
    assign wr_addr  = wr_ptr;
    assign count    = cnt;
    assign overflow = ovf;
    assign rstb     = rsta;
    assign m_data   = buf_mem[0];

    generate
        if (READ_LATENCY == 2) begin : g_regce
            assign regceb = vld[0];
        end else begin : g_noregce
            assign regceb = 1'b0;
        end
    endgenerate

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            vld    <= '0;
            occ    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_push && full) begin
                ovf <= 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, issue})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            vld[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end

            // Head sits at slot 0; a pop shifts down and capture lands behind the survivors.
            if (pop) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    buf_mem[i] <= buf_mem[i+1];
                end
            end
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (cap && (OW'(i) == occ - OW'(pop))) begin
                    buf_mem[i] <= doutb;
                end
            end
            occ <= occ + OW'(cap) - OW'(pop);
        end
    end

endmodule

// File: tb/tb_bram_queue_reader.sv
// tb/tb_bram_queue_reader.sv - directed and scoreboard bench for bram_queue_reader at both read latencies
module tb_bram_queue_reader;

    localparam int W  = 678;
    localparam int D  = 16;
    localparam int AW = 4;

    logic         clka = 1'b0;
    logic         rsta;
    logic         wr_push;
    logic [W-1:0] wdata;
    logic         m_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = g + 1;

        logic [AW-1:0] wr_addr;
        logic          full;
        logic [AW:0]   count;
        logic          overflow;
        logic [AW-1:0] addrb;
        logic          enb;
        logic          regceb;
        logic          rstb;
        logic [W-1:0]  doutb;
        logic          m_valid;
        logic [W-1:0]  m_data;

        logic [W-1:0]  mem [D];
        logic [W-1:0]  ram_q;
        logic [W-1:0]  out_q;
        logic [W-1:0]  q [$];
        logic [W-1:0]  held;
        logic [W-1:0]  exp_d;
        logic          prev_stall;

        bram_queue_reader #(
            .RAM_WIDTH    (W),
            .RAM_DEPTH    (D),
            .READ_LATENCY (LAT)
        ) dut (
            .clka     (clka),
            .rsta     (rsta),
            .wr_push  (wr_push),
            .wr_addr  (wr_addr),
            .full     (full),
            .count    (count),
            .overflow (overflow),
            .addrb    (addrb),
            .enb      (enb),
            .regceb   (regceb),
            .rstb     (rstb),
            .doutb    (doutb),
            .m_valid  (m_valid),
            .m_data   (m_data),
            .m_ready  (m_ready)
        );

        always @(posedge clka) begin
            if (wr_push && !full) mem[wr_addr] <= wdata;
            if (enb) ram_q <= mem[addrb];
            if (rstb) out_q <= '0;
            else if (regceb) out_q <= ram_q;
        end
        assign doutb = (LAT == 1) ? ram_q : out_q;

        always @(negedge clka) begin
            if (rsta) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check($sformatf("stall_hold_l%0d", LAT), m_data, held);
                if (m_valid && m_ready) begin
                    exp_d = (q.size() > 0) ? q.pop_front() : 'x;
                    check($sformatf("sb_data_l%0d", LAT), m_data, exp_d);
                end
                if (wr_push && !full) q.push_back(wdata);
                prev_stall = m_valid && !m_ready;
                held = m_data;
            end
        end
    end

    initial begin
        int bursting;
        rsta = 1'b1; wr_push = 1'b0; wdata = '0; m_ready = 1'b0;
        bursting = 0;
        repeat (2) tick();
        check("rst_mvalid", W'(lane[0].m_valid), W'(0));
        check("rst_enb", W'(lane[0].enb), W'(0));
        check("rst_regceb", W'(lane[1].regceb), W'(0));
        check("rst_full", W'(lane[0].full), W'(0));
        check("rst_wraddr", W'(lane[0].wr_addr), W'(0));
        check("rst_count", W'(lane[1].count), W'(0));
        check("rst_rstb", W'(lane[0].rstb), W'(1));
        rsta = 1'b0;
        tick();

        // single entry latency
        wr_push = 1'b1; wdata = W'('hA5); m_ready = 1'b1;
        tick();
        wr_push = 1'b0;
        check("lat_count1", W'(lane[0].count), W'(1));
        check("lat_enb_l1", W'(lane[0].enb), W'(1));
        check("lat_enb_l2", W'(lane[1].enb), W'(1));
        check("lat_wraddr", W'(lane[0].wr_addr), W'(1));
        tick();
        check("lat_mv_e1", W'(lane[0].m_valid), W'(0));
        check("lat_count0", W'(lane[0].count), W'(0));
        check("lat_regceb", W'(lane[1].regceb), W'(1));
        check("lat_addrb", W'(lane[0].addrb), W'(1));
        tick();
        check("lat_mv_l1", W'(lane[0].m_valid), W'(1));
        check("lat_md_l1", lane[0].m_data, W'('hA5));
        check("lat_mv_l2_early", W'(lane[1].m_valid), W'(0));
        tick();
        check("lat_mv_l1_done", W'(lane[0].m_valid), W'(0));
        check("lat_mv_l2", W'(lane[1].m_valid), W'(1));
        check("lat_md_l2", lane[1].m_data, W'('hA5));
        tick();

        // backpressure: reads stop once the skid buffer is committed
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_push = 1'b1; wdata = W'(256 + i);
            tick();
        end
        wr_push = 1'b0;
        repeat (4) tick();
        check("bp_count_l1", W'(lane[0].count), W'(14));
        check("bp_count_l2", W'(lane[1].count), W'(13));
        check("bp_enb_l1", W'(lane[0].enb), W'(0));
        check("bp_enb_l2", W'(lane[1].enb), W'(0));
        check("bp_head", lane[0].m_data, W'(256));
        check("bp_wraddr", W'(lane[0].wr_addr), W'(1));
        check("bp_full", W'(lane[0].full), W'(0));

        // fill to full, then an ignored push
        wr_push = 1'b1; wdata = W'(272); tick();
        wdata = W'(273); tick();
        wr_push = 1'b0;
        check("full_count", W'(lane[0].count), W'(16));
        check("full_flag", W'(lane[0].full), W'(1));
        check("full_wraddr", W'(lane[0].wr_addr), W'(3));
        check("full_ovf0", W'(lane[0].overflow), W'(0));
        check("full_l2_not", W'(lane[1].full), W'(0));
        wr_push = 1'b1; wdata = W'(274); tick();
        wr_push = 1'b0;
        check("ovf_set", W'(lane[0].overflow), W'(1));
        check("ovf_wraddr", W'(lane[0].wr_addr), W'(3));
        check("ovf_count", W'(lane[0].count), W'(16));
        check("ovf_l2_full", W'(lane[1].full), W'(1));
        check("ovf_l2_clear", W'(lane[1].overflow), W'(0));

        // push and issue together at RAM_DEPTH-1 keep full low
        m_ready = 1'b1;
        tick();
        check("bnd_count15", W'(lane[0].count), W'(15));
        check("bnd_full0", W'(lane[0].full), W'(0));
        wr_push = 1'b1; wdata = W'(275);
        tick();
        wr_push = 1'b0;
        check("bnd_count_hold", W'(lane[0].count), W'(15));
        check("bnd_full_hold", W'(lane[0].full), W'(0));
        check("bnd_wraddr", W'(lane[0].wr_addr), W'(4));
        repeat (40) tick();
        check("drain_count", W'(lane[0].count), W'(0));
        check("drain_mv", W'(lane[1].m_valid), W'(0));
        check("drain_sb", W'(lane[0].q.size()), W'(0));

        // reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_push = 1'b1; wdata = W'(512 + i);
            tick();
        end
        wr_push = 1'b0;
        rsta = 1'b1;
        #1;
        check("mrst_mv_l1", W'(lane[0].m_valid), W'(0));
        check("mrst_mv_l2", W'(lane[1].m_valid), W'(0));
        check("mrst_enb", W'(lane[1].enb), W'(0));
        check("mrst_count", W'(lane[0].count), W'(0));
        check("mrst_wraddr", W'(lane[1].wr_addr), W'(0));
        check("mrst_md", lane[0].m_data, W'(0));
        tick();
        rsta = 1'b0;
        tick();
        check("mrst_noglitch", W'(lane[1].m_valid), W'(0));
        wr_push = 1'b1; wdata = W'('h3C); m_ready = 1'b1;
        tick();
        wr_push = 1'b0;
        repeat (2) tick();
        check("mrst_first_l1", lane[0].m_data, W'('h3C));
        check("mrst_mv_after", W'(lane[0].m_valid), W'(1));
        tick();
        check("mrst_first_l2", lane[1].m_data, W'('h3C));
        tick();

        // continuous stream with pointer wrap
        for (int c = 0; c < 45; c++) begin
            wr_push = (c < 40); wdata = W'(c); m_ready = 1'b1;
            tick();
            if (c >= 2 && c < 42) begin
                check("flow_mv_l1", W'(lane[0].m_valid), W'(1));
                check("flow_md_l1", lane[0].m_data, W'(c - 2));
            end
            if (c >= 3 && c < 43) begin
                check("flow_md_l2", lane[1].m_data, W'(c - 3));
            end
        end
        check("flow_wraddr", W'(lane[0].wr_addr), W'(9));
        check("flow_addrb", W'(lane[1].addrb), W'(9));

        // random ready with bursty producer
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bursting = !bursting;
            wr_push = (bursting != 0) && !lane[0].full && !lane[1].full;
            wdata = W'($urandom);
            m_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        wr_push = 1'b0; m_ready = 1'b1;
        repeat (20) tick();
        check("rnd_sb_l1", W'(lane[0].q.size()), W'(0));
        check("rnd_sb_l2", W'(lane[1].q.size()), W'(0));
        check("rnd_count", W'(lane[1].count), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
